// File: rtl/agc_pkg.sv
// agc_pkg
// Shared definitions for the AGC gain-apply block: default widths and
// limits, the unity-gain constant and the loop FSM state type.
// Ports: none (package).
package agc_pkg;

    localparam int DEF_W_IN       = 16;
    localparam int DEF_W_LEVEL    = 48;
    localparam int DEF_W_GAIN     = 18;
    localparam int DEF_G_FRAC     = 12;
    localparam int DEF_GAIN_MIN   = 64;
    localparam int DEF_GAIN_MAX   = 262143;
    localparam int DEF_STEP_SHIFT = 4;
    localparam int DEF_LOCK_TOL   = 256;
    localparam int DEF_LOCK_CNT   = 8;

    // 1.0 in the default Q(W_GAIN-G_FRAC).G_FRAC gain format.
    localparam int GAIN_UNITY     = 4096;

    typedef enum logic {
        ACQUIRE = 1'b0,
        LOCKED  = 1'b1
    } agc_state_t;

endpackage

// File: rtl/agc_round_sat.sv
// agc_round_sat
// Combinational round-half-up, arithmetic right shift by SHIFT and
// saturation of a signed W_I-bit value to a signed W_O-bit result.
// Ports:
//   din   in  W_I  signed value to scale down
//   dout  out W_O  rounded, shifted, saturated result
module agc_round_sat #(
    parameter int W_I   = 35,
    parameter int W_O   = 16,
    parameter int SHIFT = 12
) (
    input  logic signed [W_I-1:0] din,
    output logic signed [W_O-1:0] dout
);

    // One guard bit so adding the rounding constant can never wrap.
    localparam logic signed [W_I:0] HALF  = {{(W_I-SHIFT+1){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
    localparam logic signed [W_I:0] MAX_V = {{(W_I-W_O+2){1'b0}}, {(W_O-1){1'b1}}};
    localparam logic signed [W_I:0] MIN_V = {{(W_I-W_O+2){1'b1}}, {(W_O-1){1'b0}}};

    logic signed [W_I:0] rounded;
    logic signed [W_I:0] shifted;

    assign rounded = $signed({din[W_I-1], din}) + HALF;
    assign shifted = rounded >>> SHIFT;

    always_comb begin
        if (shifted > MAX_V) begin
            dout = MAX_V[W_O-1:0];
        end else if (shifted < MIN_V) begin
            dout = MIN_V[W_O-1:0];
        end else begin
            dout = shifted[W_O-1:0];
        end
    end

endmodule

// File: rtl/agc_gain_apply.sv
// agc_gain_apply
// Applies a closed-loop AGC gain to an I/Q sample stream. The gain register
// is nudged toward target_level on every level strobe; a two-state loop
// (ACQUIRE/LOCKED) slows the step once the envelope has settled.
// Optional macro AGC_FREEZE_EN adds a freeze input that holds the loop.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   freeze (AGC_FREEZE_EN only)   1 = ignore level_valid
//   s_chans_dataI/Q, s_chans_valid input samples and strobe
//   level_data, level_valid        envelope estimate and strobe
//   target_level                   desired envelope (unsigned)
//   m_chans_dataI/Q, m_chans_valid gain-scaled samples and strobe
//   gain_out                       current gain register
//   locked                         high while the loop is LOCKED
//
// Handshake: all interfaces are strobe-only (valid, no ready). A sample is
// accepted on every rising edge where s_chans_valid is high and appears on
// m_chans_* exactly 3 cycles later; level_data/target_level are consumed on
// every rising edge where level_valid is high. Nothing can be stalled.
module agc_gain_apply
    import agc_pkg::*;
#(
    parameter int W_IN       = DEF_W_IN,
    parameter int W_LEVEL    = DEF_W_LEVEL,
    parameter int W_GAIN     = DEF_W_GAIN,
    parameter int G_FRAC     = DEF_G_FRAC,
    parameter int GAIN_MIN   = DEF_GAIN_MIN,
    parameter int GAIN_MAX   = DEF_GAIN_MAX,
    parameter int STEP_SHIFT = DEF_STEP_SHIFT,
    parameter int LOCK_TOL   = DEF_LOCK_TOL,
    parameter int LOCK_CNT   = DEF_LOCK_CNT
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef AGC_FREEZE_EN
    input  logic                      freeze,
`endif
    input  logic signed [W_IN-1:0]    s_chans_dataI,
    input  logic signed [W_IN-1:0]    s_chans_dataQ,
    input  logic                      s_chans_valid,
    input  logic        [W_LEVEL-1:0] level_data,
    input  logic                      level_valid,
    input  logic        [W_LEVEL-1:0] target_level,
    output logic signed [W_IN-1:0]    m_chans_dataI,
    output logic signed [W_IN-1:0]    m_chans_dataQ,
    output logic                      m_chans_valid,
    output logic        [W_GAIN-1:0]  gain_out,
    output logic                      locked
);

    localparam int W_PROD = W_IN + W_GAIN + 1;
    localparam int W_ERR  = W_LEVEL + 1;
    localparam int W_SUM  = W_LEVEL + 2;
    localparam int W_CNT  = $clog2(LOCK_CNT + 1);

    localparam logic signed [W_SUM-1:0] GMIN_S = W_SUM'(GAIN_MIN);
    localparam logic signed [W_SUM-1:0] GMAX_S = W_SUM'(GAIN_MAX);

    // ------------------------------------------------------------------
    // Sample path
    // ------------------------------------------------------------------
    logic                     s1_valid, s2_valid;
    logic signed [W_IN-1:0]   s1_i, s1_q;
    logic        [W_GAIN-1:0] s1_gain;
    logic signed [W_PROD-1:0] s2_pi, s2_pq;
    logic signed [W_IN-1:0]   r_i, r_q;
    logic        [W_GAIN-1:0] gain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s2_valid      <= 1'b0;
            m_chans_valid <= 1'b0;
            s1_i          <= '0;
            s1_q          <= '0;
            s1_gain       <= '0;
            s2_pi         <= '0;
            s2_pq         <= '0;
            m_chans_dataI <= '0;
            m_chans_dataQ <= '0;
        end else begin
            s1_valid      <= s_chans_valid;
            s2_valid      <= s1_valid;
            m_chans_valid <= s2_valid;
            if (s_chans_valid) begin
                s1_i    <= s_chans_dataI;
                s1_q    <= s_chans_dataQ;
                // Registered gain: the value before any same-edge update.
                s1_gain <= gain;
            end
            if (s1_valid) begin
                s2_pi <= s1_i * $signed({1'b0, s1_gain});
                s2_pq <= s1_q * $signed({1'b0, s1_gain});
            end
            if (s2_valid) begin
                m_chans_dataI <= r_i;
                m_chans_dataQ <= r_q;
            end
        end
    end

    agc_round_sat #(.W_I(W_PROD), .W_O(W_IN), .SHIFT(G_FRAC)) u_rs_i (
        .din  (s2_pi),
        .dout (r_i)
    );

    agc_round_sat #(.W_I(W_PROD), .W_O(W_IN), .SHIFT(G_FRAC)) u_rs_q (
        .din  (s2_pq),
        .dout (r_q)
    );

    // ------------------------------------------------------------------
    // Gain loop
    // ------------------------------------------------------------------
    logic upd;
`ifdef AGC_FREEZE_EN
    assign upd = level_valid & ~freeze;
`else
    assign upd = level_valid;
`endif

    agc_state_t               state, state_next;
    logic        [W_CNT-1:0]  cnt, cnt_next, cnt_inc;
    logic        [W_GAIN-1:0] gain_next, gain_clamped;
    logic signed [W_ERR-1:0]  err, step;
    logic        [W_ERR-1:0]  err_mag;
    logic signed [W_SUM-1:0]  sum;
    logic                     in_tol, far_off;

    assign err     = $signed({1'b0, target_level}) - $signed({1'b0, level_data});
    assign err_mag = err[W_ERR-1] ? $unsigned(-err) : $unsigned(err);
    assign in_tol  = (err_mag <= W_ERR'(LOCK_TOL));
    assign far_off = (err_mag >  W_ERR'(4 * LOCK_TOL));

    // Finer step once locked so the loop stops chasing envelope noise.
    assign step = (state == LOCKED) ? (err >>> (STEP_SHIFT + 2)) : (err >>> STEP_SHIFT);

    // Sum is two bits wider than the level so neither extreme can wrap.
    assign sum = $signed({{(W_SUM-W_GAIN){1'b0}}, gain}) + $signed({step[W_ERR-1], step});

    always_comb begin
        if (sum < GMIN_S) begin
            gain_clamped = W_GAIN'(GAIN_MIN);
        end else if (sum > GMAX_S) begin
            gain_clamped = W_GAIN'(GAIN_MAX);
        end else begin
            gain_clamped = sum[W_GAIN-1:0];
        end
    end

    assign cnt_inc = (cnt == W_CNT'(LOCK_CNT)) ? cnt : cnt + 1'b1;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        gain_next  = gain;
        if (upd) begin
            gain_next = gain_clamped;
            case (state)
                ACQUIRE: begin
                    if (in_tol) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc == W_CNT'(LOCK_CNT)) begin
                            state_next = LOCKED;
                        end
                    end else begin
                        cnt_next = '0;
                    end
                end
                LOCKED: begin
                    if (far_off) begin
                        state_next = ACQUIRE;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    state_next = ACQUIRE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACQUIRE;
            cnt   <= '0;
            gain  <= W_GAIN'(GAIN_UNITY);
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            gain  <= gain_next;
        end
    end

    assign gain_out = gain;
    // Decoded from the state register, so it rises with the locking update.
    assign locked   = (state == LOCKED);

endmodule

// File: tb/tb_agc_gain_apply.sv
// tb_agc_gain_apply
// Randomised, self-checking bench for agc_gain_apply. A driver issues
// samples and level updates while a behavioural model predicts the gain,
// lock flag and scaled outputs; a negedge monitor pops expected samples.
// Build with +define+AGC_FREEZE_EN to exercise the freeze input.
module tb_agc_gain_apply;

    logic               clk;
    logic               rst;
    logic               freeze;
    logic signed [15:0] s_i, s_q;
    logic               s_valid;
    logic        [47:0] level_data;
    logic               level_valid;
    logic        [47:0] target_level;
    logic signed [15:0] m_i, m_q;
    logic               m_valid;
    logic        [17:0] gain_out;
    logic               locked;

    agc_gain_apply dut (
        .clk           (clk),
        .rst           (rst),
`ifdef AGC_FREEZE_EN
        .freeze        (freeze),
`endif
        .s_chans_dataI (s_i),
        .s_chans_dataQ (s_q),
        .s_chans_valid (s_valid),
        .level_data    (level_data),
        .level_valid   (level_valid),
        .target_level  (target_level),
        .m_chans_dataI (m_i),
        .m_chans_dataQ (m_q),
        .m_chans_valid (m_valid),
        .gain_out      (gain_out),
        .locked        (locked)
    );

    // ---------------- clock / reset / cycle counter ----------------
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q[$];   // {due cycle, I, Q}
    logic [63:0] e;

    // ---------------- behavioural model ----------------
    longint m_gain   = 4096;
    bit     m_locked = 0;
    int     m_run    = 0;    // consecutive in-tolerance updates

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [15:0] model_sample(input int x);
        longint p;
        p = (longint'(x) * m_gain + 2048) >>> 12;
        if (p > 32767)  p = 32767;
        if (p < -32768) p = -32768;
        return p[15:0];
    endfunction

    task automatic model_level(input longint lvl, input longint tgt);
        longint err, mag, g;
        err = tgt - lvl;
        mag = (err < 0) ? -err : err;
        g   = m_gain + (err >>> (m_locked ? 6 : 4));
        if (g < 64)     g = 64;
        if (g > 262143) g = 262143;
        m_gain = g;
        if (!m_locked) begin
            if (mag <= 256) begin
                m_run++;
                if (m_run >= 8) m_locked = 1;
            end else begin
                m_run = 0;
            end
        end else if (mag > 1024) begin
            m_locked = 0;
            m_run    = 0;
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at posedge+1; presents inputs for one cycle, then checks the
    // loop registers just after the edge that consumed them.
    task automatic drive(input bit sv, input int i, input int q,
                         input bit lv, input longint lvl, input longint tgt, input bit frz);
        logic [15:0] ei, eq;
        s_valid      = sv;
        s_i          = i[15:0];
        s_q          = q[15:0];
        level_valid  = lv;
        level_data   = lvl[47:0];
        target_level = tgt[47:0];
        freeze       = frz;
        if (sv) begin
            ei = model_sample(i);
            eq = model_sample(q);
            exp_q.push_back({32'(cyc + 3), ei, eq});
        end
        if (lv && !frz) model_level(lvl, tgt);
        @(posedge clk);
        #1;
        s_valid     = 1'b0;
        level_valid = 1'b0;
        freeze      = 1'b0;
        check("gain_out", longint'(gain_out), m_gain);
        check("locked", longint'(locked), longint'(m_locked));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gain"},   longint'(gain_out), 4096);
        check({tag, "_locked"}, longint'(locked), 0);
        check({tag, "_mvalid"}, longint'(m_valid), 0);
        check({tag, "_mi"},     longint'(m_i), 0);
        check({tag, "_mq"},     longint'(m_q), 0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        exp_q.delete();
        m_gain   = 4096;
        m_locked = 0;
        m_run    = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("in_reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid actual=1 required=0 i=%0d q=%0d cyc=%0d", m_i, m_q, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("latency", longint'(cyc), longint'(e[63:32]));
                    check("out_i", longint'(m_i), longint'($signed(e[31:16])));
                    check("out_q", longint'(m_q), longint'($signed(e[15:0])));
                end
            end else if (exp_q.size() > 0 && int'(exp_q[0][63:32]) < cyc) begin
                e = exp_q.pop_front();
                total++;
                bad++;
                $display("FAIL missing_valid actual=0 required=1 due=%0d now=%0d", e[63:32], cyc);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst          = 1'b1;
        freeze       = 1'b0;
        s_valid      = 1'b0;
        s_i          = '0;
        s_q          = '0;
        level_valid  = 1'b0;
        level_data   = '0;
        target_level = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Unity pass-through
        drive(1, 1000, -1000, 0, 0, 0, 0);
        idle(5);

        // Single acquire step: 4096 + 10000/16
        drive(0, 0, 0, 1, 10000, 20000, 0);
        check("step_gain_const", longint'(gain_out), 4721);
        idle(2);

        // Clamp at GAIN_MAX, then saturate both rails
        drive(0, 0, 0, 1, 0, longint'(1) << 40, 0);
        check("clamp_gain_const", longint'(gain_out), 262143);
        drive(1, 32767, -32768, 0, 0, 0, 0);
        drive(1, 100, -100, 0, 0, 0, 0);
        idle(5);

        // Lock after 8 in-tolerance updates, unlock on |err| = 1025
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, 0, 1, 50000, 50000, 0);
            if (k == 6) check("lock_before_8th", longint'(locked), 0);
            if (k == 7) check("lock_on_8th", longint'(locked), 1);
        end
        drive(1, 2000, -3, 1, 50000 - 1025, 50000, 0);
        check("unlock", longint'(locked), 0);
        idle(5);

`ifdef AGC_FREEZE_EN
        // Freeze holds the loop; samples still flow
        do_reset();
        for (int k = 0; k < 5; k++) drive(k[0], 1234, -777, 1, 10000, 20000, 1);
        check("freeze_gain_const", longint'(gain_out), 4096);
        idle(5);
`endif

        // Randomised mix, including simultaneous sample/level strobes
        do_reset();
        for (int k = 0; k < 400; k++) begin
            int  tgt, dl, si, sq;
            bit  sv, lv;
            sv  = ($urandom_range(1, 0) == 1);
            lv  = ($urandom_range(3, 0) == 0);
            tgt = int'($urandom_range(40000, 20000));
            dl  = ($urandom_range(7, 0) == 0) ? int'($urandom_range(16000, 0)) - 8000
                                              : int'($urandom_range(1400, 0)) - 700;
            si  = int'($urandom_range(65535, 0)) - 32768;
            sq  = int'($urandom_range(65535, 0)) - 32768;
            drive(sv, si, sq, lv, longint'(tgt + dl), longint'(tgt), 0);
        end
        idle(5);

        // Reset with samples in flight: none of them may emerge
        drive(1, 500, 600, 1, 0, 30000, 0);
        drive(1, -500, -600, 0, 0, 0, 0);
        do_reset();
        idle(6);
        check_reset_outputs("after_midreset");

        idle(5);
        check("scoreboard_empty", longint'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
